// File: rtl/alu_tx_pkg.sv
// Shared types and frame constants for the ALU result UART transmitter.
// Frame length depends on ALU_RESULT_TX_PARITY_EN (adds one even-parity bit).
package alu_tx_pkg;

    localparam int unsigned DATA_BITS = 8;

`ifdef ALU_RESULT_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef ALU_RESULT_TX_PARITY_EN
        StParity,
`endif
        StStop
    } tx_state_e;

endpackage

// File: rtl/alu_result_tx_if.sv
// Valid/ready byte handshake between an ALU result producer and the UART transmitter.
interface alu_result_tx_if;
    import alu_tx_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/alu_tx_baud_cnt.sv
// Bit-period counter: one-cycle bit_done pulse every CLKS_PER_BIT enabled cycles.
module alu_tx_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == CntLast) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bit_done = en && (cnt_q == CntLast);

endmodule

// File: rtl/alu_result_tx.sv
// UART transmitter for ALU result bytes: 8N1 frames, or 8E1 when
// ALU_RESULT_TX_PARITY_EN is defined. Synchronous active-high reset.
module alu_result_tx
    import alu_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic             clk,
    input  logic             rst,
    alu_result_tx_if.slave   bus,
    output logic             tx,
    output logic             busy
);

    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    tx_state_e            state_q;
    logic                 tx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_idx_q;
`ifdef ALU_RESULT_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic accept;
    logic bit_done;

    assign bus.tx_ready = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign accept       = bus.tx_valid && (state_q == StIdle);
    assign tx           = tx_q;

    alu_tx_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .en       (busy),
        .bit_done (bit_done)
    );

    // Line level is registered; each transition loads the next bit onto tx_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tx_q      <= 1'b1;
            shift_q   <= '0;
            bit_idx_q <= '0;
`ifdef ALU_RESULT_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.tx_valid) begin
                        state_q   <= StStart;
                        tx_q      <= 1'b0;
                        shift_q   <= bus.tx_data;
                        bit_idx_q <= '0;
`ifdef ALU_RESULT_TX_PARITY_EN
                        parity_q  <= ^bus.tx_data;
`endif
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end
                StData: begin
                    if (bit_done) begin
                        // Index holds at the last bit; it is cleared on the next handshake.
                        if (bit_idx_q == LastBit) begin
`ifdef ALU_RESULT_TX_PARITY_EN
                            state_q <= StParity;
                            tx_q    <= parity_q;
`else
                            state_q <= StStop;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                        end
                    end
                end
`ifdef ALU_RESULT_TX_PARITY_EN
                StParity: begin
                    if (bit_done) begin
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (bit_done) begin
                        state_q <= StIdle;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_tx.sv
// Scoreboard bench for alu_result_tx at CLKS_PER_BIT=4; a monitor decodes the serial line.
module tb_alu_result_tx;
    import alu_tx_pkg::*;

    localparam int C = 4;
`ifdef ALU_RESULT_TX_PARITY_EN
    localparam int FB         = 11;
    localparam int EXP_FRAMES = 7;
`else
    localparam int FB         = 10;
    localparam int EXP_FRAMES = 5;
`endif
    localparam int FRAME_CYC = FB * C;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic clk;
    logic rst;
    logic tx;
    logic busy;

    alu_result_tx_if bus ();

    alu_result_tx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx   (tx),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   frames_seen = 0;
    exp_t sb_q[$];
    logic rst_seen = 1'b0;

    always @(posedge clk) if (rst) rst_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns with tx_valid handled; caller lands #1 after the handshake edge.
    task automatic do_handshake(input logic [7:0] b, input logic p, input bit keep,
                                output int waits);
        waits = 0;
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        check("hs_ready", {31'b0, bus.tx_ready}, 32'd1);
        @(posedge clk);
        sb_q.push_back('{data: b, par: p});
        #1;
        check("hs_ack", {29'b0, tx, bus.tx_ready, busy}, 32'b001);
        if (!keep) bus.tx_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.tx_ready && n < 300);
    endtask

    // Monitor: find a start bit, sample each bit at mid-period, compare with the scoreboard.
    initial begin
        logic [10:0] bits;
        bit          ab;
        int          t;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && rst === 1'b0) begin
                rst_seen = 1'b0;
                ab       = 1'b0;
                bits     = '1;
                t        = 1;
                while (t <= C / 2 + (FB - 1) * C && !ab) begin
                    @(negedge clk);
                    if (rst_seen) ab = 1'b1;
                    else if (t >= C / 2 && (t - C / 2) % C == 0) bits[(t - C / 2) / C] = tx;
                    t++;
                end
                if (!ab) begin
                    frames_seen++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("mon_start", {31'b0, bits[0]}, 32'd0);
                        check("mon_data", {24'b0, bits[8:1]}, {24'b0, e.data});
`ifdef ALU_RESULT_TX_PARITY_EN
                        check("mon_parity", {31'b0, bits[9]}, {31'b0, e.par});
`endif
                        check("mon_stop", {31'b0, bits[FB-1]}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int          n;
        int          w;
        logic [10:0] fa5;
`ifdef ALU_RESULT_TX_PARITY_EN
        fa5 = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        fa5 = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {29'b0, tx, bus.tx_ready, busy}, 32'b110);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle", {29'b0, tx, bus.tx_ready, busy}, 32'b110);
        end

        // 0xA5: check the line every cycle against the hand-built frame.
        do_handshake(8'hA5, 1'b0, 1'b0, w);
        for (int k = 0; k < FRAME_CYC; k++) begin
            check("a5_tx", {31'b0, tx}, {31'b0, fa5[k/C]});
            if (k == FRAME_CYC - 1) check("a5_ready_low", {31'b0, bus.tx_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("a5_ready_back", {30'b0, bus.tx_ready, busy}, 32'b10);

        // Back-to-back with tx_valid held high.
        do_handshake(8'h01, 1'b1, 1'b1, w);
        wait_ready(n);
        check("b2b_len1", n, FRAME_CYC);
        check("b2b_idle_tx", {31'b0, tx}, 32'd1);
        do_handshake(8'hFF, 1'b0, 1'b0, w);
        check("b2b_gap", w, 32'd0);
        wait_ready(n);
        check("b2b_len2", n, FRAME_CYC);

        // Input changes while busy are ignored.
        do_handshake(8'h3C, 1'b0, 1'b0, w);
        repeat (10) @(posedge clk);
        #1;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("busy_ignore", {31'b0, busy}, 32'd1);
        bus.tx_valid = 1'b0;
        wait_ready(n);
        check("ignore_len", n, FRAME_CYC - 20);

        // Abort 0x55 during data bit 3, then rst beats a simultaneous handshake.
        do_handshake(8'h55, 1'b0, 1'b0, w);
        repeat (17) @(posedge clk);
        #1;
        check("mid_bit3", {31'b0, tx}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort", {29'b0, tx, bus.tx_ready, busy}, 32'b110);
        bus.tx_data  = 8'hAA;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_priority", {29'b0, tx, bus.tx_ready, busy}, 32'b110);
        rst          = 1'b0;
        bus.tx_valid = 1'b0;
        void'(sb_q.pop_back());
        do_handshake(8'h0F, 1'b0, 1'b0, w);
        wait_ready(n);
        check("after_abort_len", n, FRAME_CYC);

`ifdef ALU_RESULT_TX_PARITY_EN
        do_handshake(8'h07, 1'b1, 1'b0, w);
        wait_ready(n);
        check("par07_len", n, 44);
        do_handshake(8'h03, 1'b0, 1'b0, w);
        wait_ready(n);
        check("par03_len", n, 44);
`endif

        repeat (20) @(posedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        check("frame_count", frames_seen, EXP_FRAMES);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
